// File: rtl/uni_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uni_pkg                                                      |
// | Description : Shared types for the unified memory request interface        |
// |               (uni_if): request type, access size, response codes, the     |
// |               request record and the arbiter state encoding.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uni_pkg;

  // Native widths of the CPU side of uni_if.
  localparam int CPU_ADDR_W  = 64;
  localparam int CPU_DATA_W  = 64;

  // Largest master count a uni arbiter is built for.
  localparam int UNI_MAX_MST = 8;

  typedef enum logic {
    UNI_READ  = 1'b0,
    UNI_WRITE = 1'b1
  } uni_reqtyp_e;

  // Access size is log2 of the byte count.
  typedef enum logic [1:0] {
    UNI_SZ_B = 2'd0,
    UNI_SZ_H = 2'd1,
    UNI_SZ_W = 2'd2,
    UNI_SZ_D = 2'd3
  } uni_size_e;

  localparam logic [1:0] UNI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] UNI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] UNI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] UNI_RESP_DECERR = 2'b11;

  typedef struct packed {
    uni_reqtyp_e             reqtyp;
    logic [CPU_ADDR_W-1:0]   addr;
    logic [CPU_DATA_W-1:0]   wdata;
    uni_size_e               size;
  } uni_req_t;

  // Arbiter FSM: IDLE arbitrates, BUSY presents the latched request.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } uni_arb_state_e;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int uni_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uni_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uni_rr_pick                                                  |
// | Description : Combinational winner selector. Fixed mode returns the lowest |
// |               eligible index; round-robin mode returns the first eligible  |
// |               index at or after the pointer, wrapping modulo N.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uni_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             rr_en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int               base;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest eligible candidate wins.
  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    base     = rr_en_i ? int'(ptr_i) : 0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = base + k;
      // Explicit wrap so non power-of-two N never yields an index >= N.
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (elig_i[cand_idx]) begin
        idx_o   = cand_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uni_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uni_arbiter                                                  |
// | Description : N-master arbiter for uni_if. Registers the grant and the     |
// |               winning request, holds it on the bridge side until the       |
// |               bridge completes, and routes the completion back to the      |
// |               granted master. Fixed-priority or round-robin policy.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uni_arbiter
  import uni_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RR_EN  = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_MST-1:0]             i_m_valid,
  input  logic [N_MST-1:0]             i_m_reqtyp,
  input  logic [N_MST-1:0][ADDR_W-1:0] i_m_addr,
  input  logic [N_MST-1:0][DATA_W-1:0] i_m_wdata,
  input  logic [N_MST-1:0][1:0]        i_m_size,
  output logic [N_MST-1:0]             o_m_ready,
  output logic [DATA_W-1:0]            o_m_rdata,
  output logic [1:0]                   o_m_resp,
  output logic                         o_s_valid,
  output logic                         o_s_reqtyp,
  output logic [ADDR_W-1:0]            o_s_addr,
  output logic [DATA_W-1:0]            o_s_wdata,
  output logic [1:0]                   o_s_size,
  input  logic                         i_s_ready,
  input  logic [DATA_W-1:0]            i_s_rdata,
  input  logic [1:0]                   i_s_resp,
  output logic [$clog2(N_MST)-1:0]     o_gnt
);

  localparam int GNT_W = $clog2(N_MST);

  uni_arb_state_e    state_q;
  logic [GNT_W-1:0]  gnt_q;
  logic [GNT_W-1:0]  rr_ptr_q;
  logic [GNT_W-1:0]  rr_ptr_d;
  logic [N_MST-1:0]  mask_q;

  uni_reqtyp_e       req_typ_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [1:0]        req_size_q;

  logic [N_MST-1:0]  eligible;
  logic [N_MST-1:0]  gnt_onehot;
  logic [GNT_W-1:0]  win_idx;
  logic              win_found;
  logic              cpl;

  // A master that just completed is masked for one cycle: its valid is still
  // high from the completing transaction and must not be granted again.
  assign eligible = i_m_valid & ~mask_q;

  uni_rr_pick #(
    .N     (N_MST),
    .IDX_W (GNT_W)
  ) u_pick (
    .elig_i  (eligible),
    .ptr_i   (rr_ptr_q),
    .rr_en_i (RR_EN != 0),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign cpl = (state_q == ARB_BUSY) && i_s_ready;

  // Decode the current grant index into a one-hot master vector.
  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < N_MST; i++) begin
      gnt_onehot[i] = (gnt_q == GNT_W'(i));
    end
  end

  // Pointer moves to the master after the one just served, wrapping at N_MST.
  assign rr_ptr_d = (gnt_q == GNT_W'(N_MST - 1)) ? '0 : gnt_q + GNT_W'(1);

  // Arbitration FSM with request register, one-cycle mask and RR pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      mask_q      <= '0;
      req_typ_q   <= UNI_READ;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_size_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          mask_q <= '0;
          if (win_found) begin
            state_q     <= ARB_BUSY;
            gnt_q       <= win_idx;
            req_typ_q   <= uni_reqtyp_e'(i_m_reqtyp[win_idx]);
            req_addr_q  <= i_m_addr[win_idx];
            req_wdata_q <= i_m_wdata[win_idx];
            req_size_q  <= i_m_size[win_idx];
          end
        end
        ARB_BUSY: begin
          // Master inputs are ignored here; the latched request runs to the end.
          if (i_s_ready) begin
            state_q <= ARB_IDLE;
            mask_q  <= gnt_onehot;
            if (RR_EN != 0) begin
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign o_s_valid  = (state_q == ARB_BUSY);
  assign o_s_reqtyp = req_typ_q;
  assign o_s_addr   = req_addr_q;
  assign o_s_wdata  = req_wdata_q;
  assign o_s_size   = req_size_q;
  assign o_gnt      = gnt_q;

  // Completion is passed straight through so the master sees it in the same
  // cycle the bridge signals it; everything is zero outside completion.
  assign o_m_ready  = cpl ? gnt_onehot : '0;
  assign o_m_rdata  = cpl ? i_s_rdata  : '0;
  assign o_m_resp   = cpl ? i_s_resp   : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_uni_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uni_arbiter                                               |
// | Description : Bench for uni_arbiter. Instance A: 2 masters, fixed          |
// |               priority. Instance B: 3 masters, round robin. Directed       |
// |               scenarios followed by randomized traffic against a           |
// |               transaction-level reference model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uni_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus storage indexed [instance][master]; instance 0 uses masters 0..1.
  logic        st_v     [2][3];
  logic        st_t     [2][3];
  logic [63:0] st_a     [2][3];
  logic [63:0] st_w     [2][3];
  logic [1:0]  st_sz    [2][3];
  logic        st_srdy  [2];
  logic [63:0] st_srd   [2];
  logic [1:0]  st_sresp [2];

  logic [1:0]       a_v, a_t, a_rdy, a_resp, a_ssz;
  logic [1:0][63:0] a_a, a_w;
  logic [1:0][1:0]  a_sz;
  logic [63:0]      a_rd, a_sa, a_sw;
  logic             a_sv, a_st;
  logic [0:0]       a_gnt;

  logic [2:0]       b_v, b_t, b_rdy;
  logic [2:0][63:0] b_a, b_w;
  logic [2:0][1:0]  b_sz;
  logic [63:0]      b_rd, b_sa, b_sw;
  logic [1:0]       b_resp, b_ssz, b_gnt;
  logic             b_sv, b_st;

  // Pack the stimulus tables onto the instance ports.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_v[i] = st_v[0][i]; a_t[i] = st_t[0][i]; a_a[i] = st_a[0][i];
      a_w[i] = st_w[0][i]; a_sz[i] = st_sz[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      b_v[i] = st_v[1][i]; b_t[i] = st_t[1][i]; b_a[i] = st_a[1][i];
      b_w[i] = st_w[1][i]; b_sz[i] = st_sz[1][i];
    end
  end

  uni_arbiter #(.N_MST(2), .ADDR_W(64), .DATA_W(64), .RR_EN(0)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_m_valid(a_v), .i_m_reqtyp(a_t), .i_m_addr(a_a), .i_m_wdata(a_w), .i_m_size(a_sz),
    .o_m_ready(a_rdy), .o_m_rdata(a_rd), .o_m_resp(a_resp),
    .o_s_valid(a_sv), .o_s_reqtyp(a_st), .o_s_addr(a_sa), .o_s_wdata(a_sw), .o_s_size(a_ssz),
    .i_s_ready(st_srdy[0]), .i_s_rdata(st_srd[0]), .i_s_resp(st_sresp[0]),
    .o_gnt(a_gnt)
  );

  uni_arbiter #(.N_MST(3), .ADDR_W(64), .DATA_W(64), .RR_EN(1)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_m_valid(b_v), .i_m_reqtyp(b_t), .i_m_addr(b_a), .i_m_wdata(b_w), .i_m_size(b_sz),
    .o_m_ready(b_rdy), .o_m_rdata(b_rd), .o_m_resp(b_resp),
    .o_s_valid(b_sv), .o_s_reqtyp(b_st), .o_s_addr(b_sa), .o_s_wdata(b_sw), .o_s_size(b_ssz),
    .i_s_ready(st_srdy[1]), .i_s_rdata(st_srd[1]), .i_s_resp(st_sresp[1]),
    .o_gnt(b_gnt)
  );

  // Reference model: one outstanding transaction per instance.
  bit          md_busy [2];
  int          md_own  [2];
  int          md_ptr  [2];
  int          md_jd   [2];   // master completed last cycle, -1 if none
  logic        md_t    [2];
  logic [63:0] md_a    [2];
  logic [63:0] md_w    [2];
  logic [1:0]  md_sz   [2];

  bit prev_rdy [2][3];
  int rr_cnt   [3];

  function automatic int n_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs present at the edge.
  task automatic model_step(input int d);
    int start, win, c;
    if (rst) begin
      md_busy[d] = 0; md_own[d] = 0; md_ptr[d] = 0; md_jd[d] = -1;
    end else if (md_busy[d]) begin
      if (st_srdy[d]) begin
        md_busy[d] = 0;
        md_jd[d]   = md_own[d];
        if (d == 1) md_ptr[d] = (md_own[d] + 1) % n_of(d);
      end
    end else begin
      start = (d == 1) ? md_ptr[d] : 0;
      win   = -1;
      for (int k = 0; k < n_of(d); k++) begin
        c = (start + k) % n_of(d);
        if (win < 0 && st_v[d][c] === 1'b1 && c != md_jd[d]) win = c;
      end
      md_jd[d] = -1;
      if (win >= 0) begin
        md_busy[d] = 1;
        md_own[d]  = win;
        md_t[d]    = st_t[d][win];
        md_a[d]    = st_a[d][win];
        md_w[d]    = st_w[d][win];
        md_sz[d]   = st_sz[d][win];
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic [7:0]  o_rdy, e_rdy;
    logic [63:0] o_rd, o_sa, o_sw, e_rd;
    logic [1:0]  o_resp, o_ssz, e_resp;
    logic        o_sv, o_st;
    logic [1:0]  o_gnt;
    bit          done;
    if (d == 0) begin
      o_rdy = {6'b0, a_rdy}; o_rd = a_rd; o_resp = a_resp; o_sv = a_sv; o_st = a_st;
      o_sa = a_sa; o_sw = a_sw; o_ssz = a_ssz; o_gnt = {1'b0, a_gnt};
    end else begin
      o_rdy = {5'b0, b_rdy}; o_rd = b_rd; o_resp = b_resp; o_sv = b_sv; o_st = b_st;
      o_sa = b_sa; o_sw = b_sw; o_ssz = b_ssz; o_gnt = b_gnt;
    end
    done   = md_busy[d] && (st_srdy[d] === 1'b1);
    e_rdy  = done ? 8'(1 << md_own[d]) : 8'h00;
    e_rd   = done ? st_srd[d] : 64'h0;
    e_resp = done ? st_sresp[d] : 2'b00;
    chk($sformatf("i%0d s_valid", d), 64'(o_sv), 64'(md_busy[d]));
    chk($sformatf("i%0d m_ready", d), 64'(o_rdy), 64'(e_rdy));
    chk($sformatf("i%0d m_rdata", d), o_rd, e_rd);
    chk($sformatf("i%0d m_resp", d), 64'(o_resp), 64'(e_resp));
    chk($sformatf("i%0d gnt", d), 64'(o_gnt), 64'(md_own[d]));
    if (md_busy[d]) begin
      chk($sformatf("i%0d s_reqtyp", d), 64'(o_st), 64'(md_t[d]));
      chk($sformatf("i%0d s_addr", d), o_sa, md_a[d]);
      chk($sformatf("i%0d s_wdata", d), o_sw, md_w[d]);
      chk($sformatf("i%0d s_size", d), 64'(o_ssz), 64'(md_sz[d]));
    end
  endtask

  // Check mid-cycle, cross one edge, then return just after it.
  task automatic tick();
    #2;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic set_req(input int d, input int i, input logic t, input logic [63:0] a,
                         input logic [63:0] w, input logic [1:0] sz);
    st_v[d][i] = 1'b1; st_t[d][i] = t; st_a[d][i] = a; st_w[d][i] = w; st_sz[d][i] = sz;
  endtask

  task automatic clear_masters();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) st_v[d][i] = 1'b0;
  endtask

  initial begin
    int done_n, guard;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st_srdy[d] = 1'b0; st_srd[d] = '0; st_sresp[d] = '0;
      for (int i = 0; i < 3; i++) begin
        st_v[d][i] = 1'b0; st_t[d][i] = 1'b0; st_a[d][i] = '0; st_w[d][i] = '0; st_sz[d][i] = '0;
        prev_rdy[d][i] = 0;
      end
    end
    @(posedge clk); model_step(0); model_step(1); #1;
    tick();

    // Reset state
    #1;
    chk("rst s_valid A", 64'(a_sv), 64'h0);
    chk("rst gnt B", 64'(b_gnt), 64'h0);
    chk("rst m_ready B", 64'(b_rdy), 64'h0);
    chk("rst s_addr A", a_sa, 64'h0);
    rst = 1'b0;
    tick();

    // Single master read on A
    set_req(0, 0, 1'b0, 64'h8000_0000, 64'h0, 2'd3);
    #1; chk("single t s_valid", 64'(a_sv), 64'h0);
    tick();
    #1; chk("single t+1 s_valid", 64'(a_sv), 64'h1);
    chk("single t+1 s_addr", a_sa, 64'h8000_0000);
    tick(); tick(); tick();
    st_srdy[0] = 1'b1; st_srd[0] = 64'hDEAD_BEEF; st_sresp[0] = 2'b00;
    #1; chk("single t+4 m_ready", 64'(a_rdy), 64'h1);
    chk("single t+4 m_rdata", a_rd, 64'hDEAD_BEEF);
    tick();
    st_v[0][0] = 1'b0; st_srdy[0] = 1'b0;
    tick();

    // Fixed-priority contention on A
    set_req(0, 0, 1'b0, 64'h100, 64'h11, 2'd2);
    set_req(0, 1, 1'b1, 64'h200, 64'h22, 2'd2);
    tick();
    #1; chk("fp first gnt", 64'(a_gnt), 64'h0);
    chk("fp first addr", a_sa, 64'h100);
    st_srdy[0] = 1'b1; st_srd[0] = 64'h1234;
    #1; chk("fp first ready", 64'(a_rdy), 64'h1);
    tick();
    st_srdy[0] = 1'b0;
    #1; chk("fp c+1 s_valid", 64'(a_sv), 64'h0);
    tick();
    #1; chk("fp c+2 s_valid", 64'(a_sv), 64'h1);
    chk("fp c+2 gnt", 64'(a_gnt), 64'h1);
    chk("fp c+2 addr", a_sa, 64'h200);
    st_v[0][0] = 1'b0; st_srdy[0] = 1'b1;
    #1; chk("fp second ready", 64'(a_rdy), 64'h2);
    tick();
    st_v[0][1] = 1'b0; st_srdy[0] = 1'b0;
    tick();

    // Round robin on B, all masters valid continuously
    for (int i = 0; i < 3; i++) begin
      set_req(1, i, 1'(i % 2), 64'h1000 * (i + 1), 64'hA0 + i, 2'd2);
      rr_cnt[i] = 0;
    end
    done_n = 0; guard = 0;
    while (done_n < 6 && guard < 60) begin
      st_srdy[1] = md_busy[1];
      st_srd[1]  = {$urandom, $urandom};
      #1;
      if (md_busy[1]) begin
        chk($sformatf("rr order %0d", done_n), 64'(b_gnt), 64'(done_n % 3));
        for (int i = 0; i < 3; i++) rr_cnt[i] += int'(b_rdy[i]);
        done_n++;
      end
      tick();
      guard++;
    end
    chk("rr completions", 64'(done_n), 64'd6);
    for (int i = 0; i < 3; i++) chk($sformatf("rr count m%0d", i), 64'(rr_cnt[i]), 64'd2);
    clear_masters(); st_srdy[1] = 1'b0;
    tick(); tick();

    // Master drops valid while BUSY on A
    set_req(0, 1, 1'b1, 64'h300, 64'h55, 2'd0);
    tick();
    st_v[0][1] = 1'b0; st_w[0][1] = 64'hAA;
    tick();
    #1; chk("drop s_wdata", a_sw, 64'h55);
    chk("drop s_valid", 64'(a_sv), 64'h1);
    st_srdy[0] = 1'b1;
    #1; chk("drop m_ready", 64'(a_rdy), 64'h2);
    tick();
    st_srdy[0] = 1'b0;
    tick();

    // Reset while BUSY on B (pointer advanced first)
    set_req(1, 0, 1'b0, 64'h4000, 64'h0, 2'd3);
    tick();
    st_srdy[1] = 1'b1;
    tick();
    st_srdy[1] = 1'b0; st_v[1][0] = 1'b0;
    set_req(1, 1, 1'b1, 64'h5000, 64'h77, 2'd3);
    tick();
    #1; chk("rstbusy gnt", 64'(b_gnt), 64'h1);
    rst = 1'b1;
    set_req(1, 0, 1'b0, 64'h6000, 64'h0, 2'd1);
    set_req(1, 2, 1'b0, 64'h7000, 64'h0, 2'd1);
    tick();
    rst = 1'b0; st_srdy[1] = 1'b1;
    #1; chk("rstbusy s_valid", 64'(b_sv), 64'h0);
    chk("rstbusy m_ready", 64'(b_rdy), 64'h0);
    tick();
    #1; chk("post-rst gnt ptr0", 64'(b_gnt), 64'h0);
    chk("post-rst addr", b_sa, 64'h6000);
    tick();
    st_v[1][0] = 1'b0;
    tick();
    #1; chk("post-rst m1 gnt", 64'(b_gnt), 64'h1);
    chk("post-rst m1 addr", b_sa, 64'h5000);
    tick();
    clear_masters(); st_srdy[1] = 1'b0;
    tick(); tick();

    // Bridge ready while IDLE on A
    st_srdy[0] = 1'b1; st_srd[0] = 64'hCAFE; st_sresp[0] = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1; chk("idle-rdy m_ready", 64'(a_rdy), 64'h0);
      chk("idle-rdy m_rdata", a_rd, 64'h0);
      tick();
    end
    chk("idle-rdy s_valid", 64'(a_sv), 64'h0);
    st_srdy[0] = 1'b0;
    tick();

    // Randomized traffic on both instances
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < n_of(d); i++) begin
          if (prev_rdy[d][i]) st_v[d][i] = 1'b0;
          else if (!st_v[d][i]) begin
            if ($urandom_range(0, 2) == 0)
              set_req(d, i, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                      {$urandom, $urandom}, 2'($urandom_range(0, 3)));
          end else if ($urandom_range(0, 49) == 0) st_v[d][i] = 1'b0;
        end
        st_srdy[d]  = md_busy[d] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
        st_srd[d]   = {$urandom, $urandom};
        st_sresp[d] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++)
          prev_rdy[d][i] = !rst && md_busy[d] && st_srdy[d] && (md_own[d] == i);
      end
      tick();
    end
    rst = 1'b0;
    clear_masters(); st_srdy[0] = 1'b0; st_srdy[1] = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
